// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder used by serial_adder to add one bit of each operand per clock.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a + b + cin one bit per clock, LSB first, through a single full-adder cell.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

  fa_cell u_fa (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        // A start seen while presenting the result chains straight into the next add.
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_sum   <= '0;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_sum   <= {w_s, r_sum[WIDTH-1:1]};
        r_carry <= w_co;
        // Hold at the final count so the counter never wraps.
        if (!w_last) r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_carry;

endmodule
